// File: rtl/bin2bcd_if.sv
// bin2bcd_if: request/result bundle between the ranging block and the BCD converter
interface bin2bcd_if #(parameter int BIN_W = 20, parameter int DIGITS = 6);
  logic [BIN_W-1:0] bin_in;
  logic bin_valid;
  logic bin_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic bcd_done;
  logic ovf;
  logic busy;
  modport master(output bin_in, bin_valid, input bin_ready, bcd_out, bcd_done, ovf, busy);
  modport slave(input bin_in, bin_valid, output bin_ready, bcd_out, bcd_done, ovf, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter, one bit per clock
module bin2bcd_seq #(
  parameter int BIN_W = 20,
  parameter int DIGITS = 6
) (
  input logic clk,
  input logic rst,
  bin2bcd_if.slave bus
);
  localparam int CW = $clog2(BIN_W);
  localparam logic [CW-1:0] LAST = CW'(BIN_W - 1);
  localparam longint unsigned LIMIT = 64'd10 ** DIGITS;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [BIN_W-1:0] sr;
  logic [4*DIGITS-1:0] acc, adj;
  logic [CW-1:0] cnt;
  logic pend;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    assign adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
  end
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  always_comb begin
    nxt = state == IDLE ? (bus.bin_valid ? SHIFT : IDLE) :
          state == SHIFT ? (cnt == LAST ? DONE : SHIFT) : IDLE;
  end
  always_comb begin
    bus.bin_ready = state == IDLE && !rst;
    bus.busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.bcd_out <= '0;
      bus.ovf <= 1'b0;
      bus.bcd_done <= 1'b0;
    end else begin
      bus.bcd_done <= state == DONE;
      if (state == IDLE && bus.bin_valid) begin
        sr <= bus.bin_in;
        acc <= '0;
        cnt <= '0;
        pend <= {{(64-BIN_W){1'b0}}, bus.bin_in} >= LIMIT;
      end
      if (state == SHIFT) begin
        {acc, sr} <= {adj, sr} << 1;
        cnt <= cnt + 1'b1;
      end
      if (state == DONE) begin
        bus.bcd_out <= pend ? {DIGITS{4'h9}} : acc;
        bus.ovf <= pend;
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed and random checks of bin2bcd_seq against an arithmetic model
module tb_bin2bcd_seq;
  logic clk, rst;
  int vectors = 0, miscompares = 0, cyc = 0;
  bin2bcd_if #(.BIN_W(20), .DIGITS(6)) bus();
  bin2bcd_seq #(.BIN_W(20), .DIGITS(6)) dut(.clk(clk), .rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [24:0] model(input int unsigned v);
    logic [24:0] r;
    r = '0;
    if (v >= 1000000) return {1'b1, 24'h999999};
    for (int i = 0; i < 6; i++) r[4*i+:4] = 4'((v / (10 ** i)) % 10);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic conv(input logic [19:0] v, input logic keep, input logic [19:0] nxt,
                      input string tag, output int acc_cyc);
    int n, bc, k;
    logic [24:0] e;
    e = model(v);
    k = 0;
    while (!bus.bin_ready && k < 50) begin tick(); k++; end
    bus.bin_in = v;
    bus.bin_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    #1;
    bus.bin_valid = keep;
    bus.bin_in = keep ? nxt : 20'($urandom);
    n = 0;
    bc = 0;
    while (!bus.bcd_done && n < 40) begin
      bc += int'(bus.busy);
      tick();
      n++;
      if (!keep && !bus.bcd_done) bus.bin_in = 20'($urandom);
    end
    chk({tag, " latency"}, n, 21);
    chk({tag, " busy"}, bc, 21);
    chk({tag, " bcd"}, bus.bcd_out, e[23:0]);
    chk({tag, " ovf"}, bus.ovf, e[24]);
    chk({tag, " ready"}, bus.bin_ready, 1);
  endtask

  initial begin
    int a0, a1, a2;
    logic [24:0] held;
    rst = 1'b1;
    bus.bin_valid = 1'b0;
    bus.bin_in = '0;
    tick();
    tick();
    chk("rst bcd", bus.bcd_out, 0);
    chk("rst done", bus.bcd_done, 0);
    chk("rst ovf", bus.ovf, 0);
    chk("rst busy", bus.busy, 0);
    chk("rst ready", bus.bin_ready, 0);
    rst = 1'b0;
    #1;
    chk("ready after rst", bus.bin_ready, 1);
    tick();
    conv(0, 1'b0, 0, "zero", a0);
    conv(123456, 1'b0, 0, "123456", a0);
    held = {bus.ovf, bus.bcd_out};
    tick();
    chk("done one cycle", bus.bcd_done, 0);
    chk("bcd held", {bus.ovf, bus.bcd_out}, held);
    conv(999999, 1'b0, 0, "999999", a0);
    conv(1000000, 1'b0, 0, "1000000", a0);
    conv(1048575, 1'b0, 0, "1048575", a0);
    conv(7, 1'b1, 58, "b2b 7", a0);
    conv(58, 1'b1, 90210, "b2b 58", a1);
    conv(90210, 1'b0, 0, "b2b 90210", a2);
    chk("spacing 1", a1 - a0, 22);
    chk("spacing 2", a2 - a1, 22);
    conv(4321, 1'b0, 0, "4321", a0);
    bus.bin_in = 5555;
    bus.bin_valid = 1'b1;
    tick();
    bus.bin_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort no done", bus.bcd_done, 0);
    end
    rst = 1'b1;
    #1;
    chk("ready in rst", bus.bin_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort bcd", bus.bcd_out, 0);
    chk("abort ovf", bus.ovf, 0);
    chk("abort done", bus.bcd_done, 0);
    chk("abort ready", bus.bin_ready, 1);
    for (int i = 0; i < 25; i++) begin
      tick();
      chk("abort quiet", bus.bcd_done, 0);
    end
    conv(88, 1'b0, 0, "88", a0);
    for (int i = 0; i < 2000; i++) conv(20'($urandom), 1'b0, 0, "random", a0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
